// File: rtl/cond_flag_unit.sv
// cond_flag_unit: execute-stage condition evaluation and NZCV flag register.
// Evaluates each instruction's condition field against the committed flags,
// gates the PC/register/memory write enables, keeps a shadow copy of the flags
// for exception entry/return and a sticky illegal-condition indicator.
// Optional statistics counters are enabled by defining COND_STATS_EN.
module cond_flag_unit #(
  parameter logic [3:0]  RESET_FLAGS = 4'b0000,
  parameter int unsigned STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Valid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [3:0]        Cond,
  input  logic [3:0]        ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  input  logic              ExcEnter,
  input  logic              ExcReturn,
  output logic              CondEx,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic [3:0]        Flags,
  output logic [3:0]        SFlags,
  output logic              CondIllegal,
  output logic [STAT_W-1:0] ExecCnt,
  output logic [STAT_W-1:0] SquashCnt
);

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_e;

  logic [3:0] flags_q;
  logic [3:0] sflags_q;
  logic       illegal_q;
  logic       commit;
  logic       cond_ex;
  logic       fn, fz, fc, fv;
  cond_e      cond;

  assign {fn, fz, fc, fv} = flags_q;
  assign cond   = cond_e'(Cond);
  assign commit = Valid & ~Stall & ~Flush;

  // Condition check against the registered flags only (no bypass of ALUFlags)
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      C_EQ: cond_ex = fz;
      C_NE: cond_ex = ~fz;
      C_CS: cond_ex = fc;
      C_CC: cond_ex = ~fc;
      C_MI: cond_ex = fn;
      C_PL: cond_ex = ~fn;
      C_VS: cond_ex = fv;
      C_VC: cond_ex = ~fv;
      C_HI: cond_ex = fc & ~fz;
      C_LS: cond_ex = ~fc | fz;
      C_GE: cond_ex = (fn == fv);
      C_LT: cond_ex = (fn != fv);
      C_GT: cond_ex = ~fz & (fn == fv);
      C_LE: cond_ex = fz | (fn != fv);
      C_AL: cond_ex = 1'b1;
      C_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  // Downstream enables: zero-latency gating by commit and condition result
  always_comb begin
    CondEx   = cond_ex;
    PCSrc    = commit & cond_ex & PCS;
    RegWrite = commit & cond_ex & RegW & ~NoWrite;
    MemWrite = commit & cond_ex & MemW;
  end

  // Flag and shadow-flag registers; exception entry beats return, and both
  // take priority over the instruction's own flag write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= RESET_FLAGS;
      sflags_q <= RESET_FLAGS;
    end else if (ExcEnter) begin
      sflags_q <= flags_q;
    end else if (ExcReturn) begin
      flags_q <= sflags_q;
    end else if (commit && cond_ex) begin
      if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Sticky illegal-condition flag, set only by a committing Cond=F
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (commit && (cond == C_NV)) begin
      illegal_q <= 1'b1;
    end
  end

  assign Flags       = flags_q;
  assign SFlags      = sflags_q;
  assign CondIllegal = illegal_q;

`ifdef COND_STATS_EN
  logic [STAT_W-1:0] exec_q;
  logic [STAT_W-1:0] squash_q;

  // Saturating counters of committed passed / failed instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_q   <= '0;
      squash_q <= '0;
    end else if (commit) begin
      if (cond_ex && (exec_q != '1))
        exec_q <= exec_q + 1'b1;
      if (!cond_ex && (squash_q != '1))
        squash_q <= squash_q + 1'b1;
    end
  end

  assign ExecCnt   = exec_q;
  assign SquashCnt = squash_q;
`else
  assign ExecCnt   = '0;
  assign SquashCnt = '0;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit with hand-computed expected values.
// Define COND_STATS_EN at build time to exercise the statistics counters.
module tb_cond_flag_unit;

  localparam int unsigned SW = 4;

  logic          clk;
  logic          rst_n;
  logic          Valid, Stall, Flush;
  logic [3:0]    Cond, ALUFlags;
  logic [1:0]    FlagW;
  logic          PCS, RegW, MemW, NoWrite, ExcEnter, ExcReturn;
  logic          CondEx, PCSrc, RegWrite, MemWrite, CondIllegal;
  logic [3:0]    Flags, SFlags;
  logic [SW-1:0] ExecCnt, SquashCnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  cond_flag_unit #(.RESET_FLAGS(4'b0000), .STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .Valid(Valid), .Stall(Stall), .Flush(Flush),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .ExcEnter(ExcEnter), .ExcReturn(ExcReturn),
    .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .SFlags(SFlags), .CondIllegal(CondIllegal),
    .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk all 16 condition codes with Valid low; bit i of exp is CondEx for Cond=i
  task automatic sweep(input string tag, input logic [15:0] exp);
    for (int i = 0; i < 16; i++) begin
      Cond = 4'(i);
      #1;
      check($sformatf("%s_cond%0h", tag, i), {31'b0, CondEx}, {31'b0, exp[i]});
    end
  endtask

  initial begin
    rst_n = 1'b0; Valid = 0; Stall = 0; Flush = 0; Cond = 4'h0; ALUFlags = 4'h0;
    FlagW = 2'b00; PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; ExcEnter = 0; ExcReturn = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", Flags, 4'b0000);
    check("rst_sflags", SFlags, 4'b0000);
    check("rst_illegal", CondIllegal, 1'b0);
    check("rst_exec", ExecCnt, 0);
    check("rst_squash", SquashCnt, 0);
    check("rst_condex_eq", CondEx, 1'b0);
    rst_n = 1'b1;

    // AL with RegW passes
    Valid = 1; Cond = 4'hE; RegW = 1; #1;
    check("al_condex", CondEx, 1'b1);
    check("al_regwrite", RegWrite, 1'b1);
    check("al_pcsrc", PCSrc, 1'b0);
    check("al_memwrite", MemWrite, 1'b0);
    check("al_flags", Flags, 4'b0000);
    tick();

    // Full flag write
    RegW = 0; FlagW = 2'b11; ALUFlags = 4'b0100; #1;
    check("nobypass_eq_before", Flags, 4'b0000);
    tick();
    check("flags_0100", Flags, 4'b0100);
    Valid = 0; FlagW = 2'b00;
    sweep("tbl0100", 16'h66A9);

    // EQ passes, NE fails and must not write flags
    Valid = 1; Cond = 4'h0; MemW = 1; #1;
    check("eq_condex", CondEx, 1'b1);
    check("eq_memwrite", MemWrite, 1'b1);
    tick();
    Cond = 4'h1; FlagW = 2'b11; ALUFlags = 4'b1111; #1;
    check("ne_condex", CondEx, 1'b0);
    check("ne_memwrite", MemWrite, 1'b0);
    tick();
    check("ne_flags_hold", Flags, 4'b0100);

    // Partial writes
    MemW = 0; Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b1011;
    tick();
    check("flagw10", Flags, 4'b1000);
    Valid = 0;
    sweep("tbl1000", 16'h6A9A);
    Valid = 1; Cond = 4'hE; FlagW = 2'b01; ALUFlags = 4'b0011;
    tick();
    check("flagw01", Flags, 4'b1011);
    Valid = 0;
    sweep("tbl1011", 16'h5556);

    // NoWrite suppresses only RegWrite
    Valid = 1; Cond = 4'hE; RegW = 1; NoWrite = 1; PCS = 1; #1;
    check("nowrite_regwrite", RegWrite, 1'b0);
    check("nowrite_pcsrc", PCSrc, 1'b1);
    FlagW = 2'b01; ALUFlags = 4'b0010;
    tick();
    check("flags_1010", Flags, 4'b1010);
    RegW = 0; NoWrite = 0; PCS = 0;

    // Exception entry saves and suppresses the instruction update
    ExcEnter = 1; FlagW = 2'b11; ALUFlags = 4'b0101;
    tick();
    check("exc_enter_sflags", SFlags, 4'b1010);
    check("exc_enter_flags", Flags, 4'b1010);
    ExcEnter = 0; ALUFlags = 4'b0000;
    tick();
    check("overwrite_flags", Flags, 4'b0000);
    ExcReturn = 1; ALUFlags = 4'b1111;
    tick();
    check("exc_return_flags", Flags, 4'b1010);
    ExcReturn = 0; ALUFlags = 4'b0001;
    tick();
    check("flags_0001", Flags, 4'b0001);
    ExcEnter = 1; ExcReturn = 1; ALUFlags = 4'b1111;
    tick();
    check("both_sflags", SFlags, 4'b0001);
    check("both_flags", Flags, 4'b0001);
    ExcEnter = 0; ExcReturn = 0;

    // Stall: nothing commits, illegal not set
    Stall = 1; Cond = 4'hF; MemW = 1; RegW = 1; PCS = 1; #1;
    check("stall_pcsrc", PCSrc, 1'b0);
    check("stall_regwrite", RegWrite, 1'b0);
    check("stall_memwrite", MemWrite, 1'b0);
    repeat (5) tick();
    check("stall_illegal", CondIllegal, 1'b0);
    check("stall_flags", Flags, 4'b0001);
    check("stall_sflags", SFlags, 4'b0001);
    Cond = 4'hE; #1;
    check("stall_al_condex", CondEx, 1'b1);
    check("stall_al_regwrite", RegWrite, 1'b0);
    tick();
    check("stall_al_flags", Flags, 4'b0001);

    // Flush also blocks the illegal flag
    Stall = 0; Flush = 1; Cond = 4'hF; #1;
    check("flush_memwrite", MemWrite, 1'b0);
    tick();
    check("flush_illegal", CondIllegal, 1'b0);
    Flush = 0; FlagW = 2'b00; #1;
    check("nv_condex", CondEx, 1'b0);
    check("nv_pcsrc", PCSrc, 1'b0);
    tick();
    check("nv_illegal_set", CondIllegal, 1'b1);
    Valid = 0; MemW = 0; RegW = 0; PCS = 0;
    repeat (3) tick();
    check("illegal_sticky", CondIllegal, 1'b1);

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("async_illegal", CondIllegal, 1'b0);
    check("async_flags", Flags, 4'b0000);
    check("async_sflags", SFlags, 4'b0000);
    #3 rst_n = 1'b1;
    tick();

`ifdef COND_STATS_EN
    Valid = 1; Cond = 4'hE; FlagW = 2'b00;
    repeat (20) tick();
    check("exec_sat", ExecCnt, 15);
    check("squash_zero", SquashCnt, 0);
    FlagW = 2'b11; ALUFlags = 4'b0100;
    tick();
    FlagW = 2'b00; Cond = 4'h1;
    repeat (3) tick();
    check("squash_3", SquashCnt, 3);
    check("exec_hold", ExecCnt, 15);
    Flush = 1;
    repeat (2) tick();
    check("flush_squash", SquashCnt, 3);
    check("flush_exec", ExecCnt, 15);
    Flush = 0; Valid = 0;
`else
    Valid = 1; Cond = 4'hE; FlagW = 2'b00;
    repeat (3) tick();
    check("nostat_exec", ExecCnt, 0);
    check("nostat_squash", SquashCnt, 0);
    Valid = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Execute-stage companion to the 32-bit ALU. It consumes the ALU's NZCV flags, which arrive as {N,Z,C,V}.
- Holds the architectural condition-flag register and evaluates each instruction's 4-bit condition field.
- Gates the PC-select, register-write and memory-write enables before they travel downstream.
- Adds a shadow flag register for exception entry/return and a sticky illegal-condition indicator.

Parameters:
- RESET_FLAGS, 4'b0000, value loaded into Flags and SFlags on reset.
- STAT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Valid  in  1  an instruction is present in the execute stage.
- Stall  in  1  execute stage is held this cycle; nothing commits.
- Flush  in  1  execute-stage instruction is squashed; nothing commits.
- Cond  in  4  instruction condition field.
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  in  2  bit1 = write N,Z; bit0 = write C,V.
- PCS  in  1  instruction writes the PC.
- RegW  in  1  instruction writes the register file.
- MemW  in  1  instruction writes memory.
- NoWrite  in  1  compare-type instruction; suppresses RegWrite only.
- ExcEnter  in  1  exception entry; saves flags.
- ExcReturn  in  1  exception return; restores flags.
- CondEx  out  1  condition passes, evaluated on the registered Flags.
- PCSrc  out  1  gated PCS.
- RegWrite  out  1  gated RegW.
- MemWrite  out  1  gated MemW.
- Flags  out  4  architectural {N,Z,C,V} register.
- SFlags  out  4  saved flags register.
- CondIllegal  out  1  sticky; set when an illegal condition commits.
- ExecCnt  out  STAT_W  count of committed, condition-passed instructions (optional feature).
- SquashCnt  out  STAT_W  count of committed, condition-failed instructions (optional feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - Flags = SFlags = RESET_FLAGS.
  - CondIllegal = 0; counters = 0.
  - Combinational outputs follow from the reset state.
- CondEx is combinational on the registered Flags and Cond:
  - 0 EQ: Z. 1 NE: ~Z. 2 CS: C. 3 CC: ~C.
  - 4 MI: N. 5 PL: ~N. 6 VS: V. 7 VC: ~V.
  - 8 HI: C&~Z. 9 LS: ~C|Z.
  - A GE: N==V. B LT: N!=V.
  - C GT: ~Z&(N==V). D LE: Z|(N!=V).
  - E AL: 1. F: 0 (illegal).
- commit = Valid & ~Stall & ~Flush.
- Output gating, all combinational, zero latency:
  - PCSrc = commit & CondEx & PCS.
  - RegWrite = commit & CondEx & RegW & ~NoWrite.
  - MemWrite = commit & CondEx & MemW.
- Flag update at the clock edge when commit & CondEx:
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1].
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0].
  - Bits not selected by FlagW hold their value.
- No bypass: an instruction's condition always sees flags from earlier committed instructions, never its own ALUFlags.
- ExcEnter: SFlags <= Flags (pre-update value). This cycle's instruction flag update is suppressed, even if Flush is not asserted.
- ExcReturn (without ExcEnter): Flags <= SFlags, overriding any instruction flag update in the same cycle.
- ExcEnter and ExcReturn together: ExcEnter wins; ExcReturn is ignored.
- Cond == 4'hF with commit: CondIllegal <= 1, held until reset. With Stall or Flush, CondIllegal is not set.
- Stall held for many cycles: Flags, SFlags and CondIllegal are unchanged; outputs stay deasserted.
- Mid-operation reset: state is cleared immediately, regardless of clk.

Optional Feature:
- COND_STATS_EN defined:
  - ExecCnt increments on commit & CondEx.
  - SquashCnt increments on commit & ~CondEx.
  - Both saturate at all-ones (no wrap) and clear on reset.
- COND_STATS_EN undefined: ExecCnt and SquashCnt are driven constant 0 and no counter registers are inferred.

Test Plan:
- Reset release, Cond=E, Valid=1, RegW=1 -> CondEx=1, RegWrite=1, Flags=0000.
- Commit FlagW=11, ALUFlags=0100, then Cond=0 (EQ) with MemW=1 -> Flags=0100 next cycle; MemWrite=1. Same with Cond=1 (NE) -> MemWrite=0, Flags unchanged.
- Flags=0100, FlagW=10, ALUFlags=1011 -> Flags=1000 (C,V held). Then FlagW=01, ALUFlags=0011 -> Flags=1011.
- Flags=1010, ExcEnter=1 -> SFlags=1010. Overwrite Flags to 0000, then ExcReturn=1 with a committing FlagW=11 instruction -> Flags=1010. Assert ExcEnter and ExcReturn together -> SFlags updated, Flags unchanged.
- Cond=F with Stall=1 -> CondIllegal=0, all enables 0. Release Stall -> CondIllegal=1 and stays 1. Pulse rst_n low mid-cycle -> CondIllegal=0 and Flags=RESET_FLAGS immediately.
- With COND_STATS_EN and STAT_W=4: 20 AL commits -> ExecCnt=15 (saturated). 3 failing NE commits -> SquashCnt=3. 2 flushed instructions -> no count change.
